// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA ball renderer.
// Timing defaults, colour levels and FSM encoding.
package vga_pkg;

   localparam int DEF_ACTIVE_COLS = 640;
   localparam int DEF_ACTIVE_ROWS = 480;
   localparam int DEF_TOTAL_COLS  = 800;
   localparam int DEF_TOTAL_ROWS  = 525;

   localparam logic [2:0] BLACK    = 3'b000;
   localparam logic [2:0] WHITE    = 3'b111;
   localparam logic [2:0] GRID_GRN = 3'b010;
   localparam logic [2:0] BG_BLU   = 3'b001;

   typedef enum logic [1:0] {
      S_DRAW   = 2'd0,
      S_MOVE_X = 2'd1,
      S_MOVE_Y = 2'd2
   } state_t;

   typedef struct packed {
      logic [2:0] red;
      logic [2:0] grn;
      logic [2:0] blu;
   } rgb_t;

endpackage

// File: rtl/ball_axis_mover.sv
// One axis of ball motion: position, direction and bounce flag.
// Moves by SPEED when enabled and reflects off 0 and LIMIT-SIZE.
module ball_axis_mover #(
   parameter int LIMIT    = 640,
   parameter int SIZE     = 8,
   parameter int SPEED    = 2,
   parameter int INIT     = 128,
   parameter bit INIT_NEG = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       move,
   input  logic       clr,
   output logic [9:0] pos,
   output logic       flag_nxt
);

   localparam logic [10:0] MAX_POS = 11'(LIMIT - SIZE);
   localparam logic [10:0] SPD     = 11'(SPEED);

   logic        neg;
   logic        flag;
   logic        hit;
   logic [10:0] cur;
   logic [10:0] fwd;
   logic [10:0] nxt_pos;

   assign cur = {1'b0, pos};
   assign fwd = cur + SPD;

   // 11-bit compares keep both walls wrap-free
   always_comb begin
      hit     = 1'b0;
      nxt_pos = cur;
      if (neg) begin
         hit     = (cur <= SPD);
         nxt_pos = hit ? 11'd0 : cur - SPD;
      end else begin
         hit     = (fwd >= MAX_POS);
         nxt_pos = hit ? MAX_POS : fwd;
      end
   end

   always_comb begin
      flag_nxt = flag;
      if (clr)
         flag_nxt = 1'b0;
      else if (move && hit)
         flag_nxt = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos  <= 10'(INIT);
         neg  <= INIT_NEG;
         flag <= 1'b0;
      end else begin
         flag <= flag_nxt;
         if (move) begin
            pos <= nxt_pos[9:0];
            if (hit)
               neg <= ~neg;
         end
      end
   end

endmodule

// File: rtl/vga_ball_renderer.sv
// Draws a bouncing square ball over a grid between sync and porch stages.
// Video and sync are registered together so they stay column-aligned.
module vga_ball_renderer
   import vga_pkg::*;
#(
   parameter int ACTIVE_COLS = DEF_ACTIVE_COLS,
   parameter int ACTIVE_ROWS = DEF_ACTIVE_ROWS,
   parameter int BALL_SIZE   = 8,
   parameter int SPEED       = 2,
   parameter int INIT_X      = 128,
   parameter int INIT_Y      = 128,
   parameter bit INIT_X_NEG  = 1'b0,
   parameter bit INIT_Y_NEG  = 1'b0
) (
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   input  logic       i_HSync,
   input  logic       i_VSync,
   input  logic [9:0] i_Col_Count,
   input  logic [9:0] i_Row_Count,
   output logic       o_HSync,
   output logic       o_VSync,
   output logic [2:0] o_Red_Video,
   output logic [2:0] o_Grn_Video,
   output logic [2:0] o_Blu_Video,
   output logic       o_Bounce
);

   localparam logic [10:0] SZ = 11'(BALL_SIZE);

   state_t      state;
   state_t      state_nxt;
   logic        trig;
   logic        move_x;
   logic        move_y;
   logic        clr;
   logic        bounce_now;
   logic [9:0]  pos_x;
   logic [9:0]  pos_y;
   logic        fx_nxt;
   logic        fy_nxt;
   logic [10:0] col_w;
   logic [10:0] row_w;
   logic        in_ball;
   logic        grid;
   rgb_t        pix;

   // First blanking line, column 0: once per frame
   assign trig = (i_Row_Count == 10'(ACTIVE_ROWS)) &&
                 (i_Col_Count == 10'd0);

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L)
         state <= S_DRAW;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_DRAW:   if (trig) state_nxt = S_MOVE_X;
         S_MOVE_X: state_nxt = S_MOVE_Y;
         S_MOVE_Y: state_nxt = S_DRAW;
         default:  state_nxt = S_DRAW;
      endcase
   end

   always_comb begin
      move_x     = (state == S_MOVE_X);
      move_y     = (state == S_MOVE_Y);
      clr        = (state == S_DRAW) && trig;
      bounce_now = move_y;
   end

   ball_axis_mover #(
      .LIMIT(ACTIVE_COLS), .SIZE(BALL_SIZE), .SPEED(SPEED),
      .INIT(INIT_X), .INIT_NEG(INIT_X_NEG)
   ) u_x (
      .clk(i_Clk), .rst_n(i_Rst_L), .move(move_x), .clr(clr),
      .pos(pos_x), .flag_nxt(fx_nxt)
   );

   ball_axis_mover #(
      .LIMIT(ACTIVE_ROWS), .SIZE(BALL_SIZE), .SPEED(SPEED),
      .INIT(INIT_Y), .INIT_NEG(INIT_Y_NEG)
   ) u_y (
      .clk(i_Clk), .rst_n(i_Rst_L), .move(move_y), .clr(clr),
      .pos(pos_y), .flag_nxt(fy_nxt)
   );

   assign col_w = {1'b0, i_Col_Count};
   assign row_w = {1'b0, i_Row_Count};

   always_comb begin
      in_ball = (col_w >= {1'b0, pos_x}) &&
                (col_w <  {1'b0, pos_x} + SZ) &&
                (row_w >= {1'b0, pos_y}) &&
                (row_w <  {1'b0, pos_y} + SZ);
      grid    = (i_Col_Count[2:0] == 3'd0) ||
                (i_Row_Count[2:0] == 3'd0);
   end

   always_comb begin
      pix = '{red: BLACK, grn: BLACK, blu: BLACK};
      if (i_HSync && i_VSync) begin
         if (in_ball)
            pix = '{red: WHITE, grn: WHITE, blu: WHITE};
         else if (grid)
            pix.grn = GRID_GRN;
         else
            pix.blu = BG_BLU;
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         o_HSync     <= 1'b0;
         o_VSync     <= 1'b0;
         o_Red_Video <= BLACK;
         o_Grn_Video <= BLACK;
         o_Blu_Video <= BLACK;
         o_Bounce    <= 1'b0;
      end else begin
         o_HSync     <= i_HSync;
         o_VSync     <= i_VSync;
         o_Red_Video <= pix.red;
         o_Grn_Video <= pix.grn;
         o_Blu_Video <= pix.blu;
         o_Bounce    <= bounce_now && (fx_nxt || fy_nxt);
      end
   end

endmodule

// File: tb/tb_vga_ball_renderer.sv
// Bench for vga_ball_renderer: three instances (centre, right wall, corner)
// driven by shared counters and checked against a per-frame ball model.
module tb_vga_ball_renderer;

   logic       i_Clk = 1'b0;
   logic       i_Rst_L = 1'b0;
   logic       i_HSync = 1'b0;
   logic       i_VSync = 1'b0;
   logic [9:0] i_Col_Count = '0;
   logic [9:0] i_Row_Count = '0;

   logic [12:0] obs [3];
   logic        hs [3];
   logic        vs [3];
   logic [2:0]  rr [3];
   logic [2:0]  gg [3];
   logic [2:0]  bb [3];
   logic        bn [3];

   int ncmp = 0;
   int nfail = 0;

   int mx [3];
   int my [3];
   bit nx [3];
   bit ny [3];
   bit bflag [3];
   bit bwin = 1'b0;
   int cur_c = 0;
   int cur_r = 0;

   localparam int IX [3] = '{128, 631, 1};
   localparam int IY [3] = '{128, 128, 1};
   localparam bit IN [3] = '{1'b0, 1'b0, 1'b1};

   always #5 i_Clk = ~i_Clk;

   vga_ball_renderer u0 (
      .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_HSync(i_HSync),
      .i_VSync(i_VSync), .i_Col_Count(i_Col_Count),
      .i_Row_Count(i_Row_Count), .o_HSync(hs[0]), .o_VSync(vs[0]),
      .o_Red_Video(rr[0]), .o_Grn_Video(gg[0]), .o_Blu_Video(bb[0]),
      .o_Bounce(bn[0])
   );

   vga_ball_renderer #(.INIT_X(631)) u1 (
      .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_HSync(i_HSync),
      .i_VSync(i_VSync), .i_Col_Count(i_Col_Count),
      .i_Row_Count(i_Row_Count), .o_HSync(hs[1]), .o_VSync(vs[1]),
      .o_Red_Video(rr[1]), .o_Grn_Video(gg[1]), .o_Blu_Video(bb[1]),
      .o_Bounce(bn[1])
   );

   vga_ball_renderer #(
      .INIT_X(1), .INIT_Y(1), .INIT_X_NEG(1'b1), .INIT_Y_NEG(1'b1)
   ) u2 (
      .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_HSync(i_HSync),
      .i_VSync(i_VSync), .i_Col_Count(i_Col_Count),
      .i_Row_Count(i_Row_Count), .o_HSync(hs[2]), .o_VSync(vs[2]),
      .o_Red_Video(rr[2]), .o_Grn_Video(gg[2]), .o_Blu_Video(bb[2]),
      .o_Bounce(bn[2])
   );

   always_comb
      for (int i = 0; i < 3; i++)
         obs[i] = {hs[i], vs[i], rr[i], gg[i], bb[i], bn[i]};

   function automatic logic [8:0] exp_px(int c, int r, int bx, int by);
      if (c >= 640 || r >= 480) return 9'd0;
      if (c >= bx && c < bx + 8 && r >= by && r < by + 8) return 9'h1FF;
      if (c % 8 == 0 || r % 8 == 0) return 9'b000_010_000;
      return 9'b000_000_001;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         mx[i] = IX[i]; my[i] = IY[i];
         nx[i] = IN[i]; ny[i] = IN[i];
         bflag[i] = 1'b0;
      end
   endtask

   task automatic axis(inout int p, inout bit neg, input int lim,
                       inout bit b);
      int hi;
      hi = lim - 8;
      if (!neg) begin
         if (p + 2 >= hi) begin p = hi; neg = 1'b1; b = 1'b1; end
         else p = p + 2;
      end else begin
         if (p <= 2) begin p = 0; neg = 1'b0; b = 1'b1; end
         else p = p - 2;
      end
   endtask

   task automatic model_frame();
      for (int i = 0; i < 3; i++) begin
         bflag[i] = 1'b0;
         axis(mx[i], nx[i], 640, bflag[i]);
         axis(my[i], ny[i], 480, bflag[i]);
      end
   endtask

   task automatic check_all(string tag);
      logic [12:0] e;
      for (int i = 0; i < 3; i++) begin
         e = '0;
         if (i_Rst_L)
            e = {cur_c < 640, cur_r < 480,
                 exp_px(cur_c, cur_r, mx[i], my[i]), bwin & bflag[i]};
         ncmp++;
         assert (obs[i] === e) else begin
            nfail++;
            $error("FAIL %s dut%0d col=%0d row=%0d got %h expected %h",
                   tag, i, cur_c, cur_r, obs[i], e);
         end
      end
   endtask

   task automatic px(int c, int r, string tag);
      cur_c = c; cur_r = r;
      i_Col_Count = 10'(c);
      i_Row_Count = 10'(r);
      i_HSync = (c < 640);
      i_VSync = (r < 480);
      @(posedge i_Clk);
      #1;
      check_all(tag);
   endtask

   task automatic frame();
      model_frame();
      bwin = 1'b0;
      px(0, 480, "trig");
      for (int k = 1; k <= 3; k++) begin
         bwin = (k == 2);
         px(k, 480, "bounce");
      end
      bwin = 1'b0;
   endtask

   task automatic rnd(int n);
      int c, r, d;
      for (int k = 0; k < n; k++) begin
         d = k % 3;
         if (k % 2 == 0) begin
            c = mx[d] + int'($urandom_range(0, 11)) - 2;
            r = my[d] + int'($urandom_range(0, 11)) - 2;
            if (c < 0) c = 0;
            if (r < 0) r = 0;
         end else begin
            c = int'($urandom_range(0, 799));
            r = int'($urandom_range(0, 524));
         end
         if (r == 480 && c == 0) c = 1;
         px(c, r, "rand");
      end
   endtask

   initial begin
      model_reset();
      i_Rst_L = 1'b0;
      for (int k = 0; k < 4; k++)
         px(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
            "rst_hold");
      i_Rst_L = 1'b1;
      px(128, 128, "release");
      px(8, 3, "grid");
      px(9, 3, "bg");
      px(700, 3, "blank");
      px(5, 200, "sync");
      rnd(30);

      frame();
      px(129, 129, "mv_bg");
      px(130, 130, "mv_ball");
      px(632, 130, "wall_in");
      px(631, 130, "wall_out");
      px(0, 0, "corner_in");
      px(7, 7, "corner_edge");
      px(8, 8, "corner_out");
      rnd(30);

      frame();
      px(630, 132, "wall_back");
      px(2, 2, "corner_back");
      rnd(20);

      px(50, 200, "pre_rst");
      i_Rst_L = 1'b0;
      model_reset();
      #1;
      check_all("rst_async");
      px(51, 200, "rst_mid");
      px(52, 200, "rst_mid");
      i_Rst_L = 1'b1;
      px(128, 128, "rst_pos");
      px(130, 130, "rst_old");
      frame();
      px(130, 130, "rst_move");
      px(129, 129, "rst_move_bg");
      rnd(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               ncmp, nfail);
      $finish;
   end

endmodule

// File: doc/vga_ball_renderer.md
# vga_ball_renderer

Pixel-generation stage between `VGA_Sync_Pulses` and `VGA_Sync_Porch`. It consumes the column/row counters and raw sync pulses, and draws a square ball over a grid background. The ball position advances once per frame and bounces off the active-area edges. Outputs are registered, with the sync pulses delayed to match, so the porch stage receives aligned sync and video.

## Interface
- `ACTIVE_COLS`, 640: visible columns.
- `ACTIVE_ROWS`, 480: visible rows.
- `BALL_SIZE`, 8: ball edge length in pixels (≥1, < both active dimensions).
- `SPEED`, 2: pixels moved per frame on each axis (1..BALL_SIZE).
- `INIT_X`, 128: ball left edge after reset.
- `INIT_Y`, 128: ball top edge after reset.

Ports:
- `i_Clk` in 1: pixel clock.
- `i_Rst_L` in 1: asynchronous, active-low reset; one clock domain only.
- `i_HSync` in 1: raw HSync from the sync-pulse generator; high while column < `ACTIVE_COLS`.
- `i_VSync` in 1: raw VSync; high while row < `ACTIVE_ROWS`.
- `i_Col_Count` in 10: current column, 0..TOTAL_COLS-1.
- `i_Row_Count` in 10: current row, 0..TOTAL_ROWS-1.
- `o_HSync` out 1: `i_HSync` delayed 1 cycle.
- `o_VSync` out 1: `i_VSync` delayed 1 cycle.
- `o_Red_Video` out 3: red level.
- `o_Grn_Video` out 3: green level.
- `o_Blu_Video` out 3: blue level.
- `o_Bounce` out 1: single-cycle pulse on any wall hit (sound hook).

## Operation
- **Reset (async assert, sync-safe release):**
  - X=`INIT_X`, Y=`INIT_Y`, both directions positive (right/down).
  - FSM=S_DRAW.
  - All outputs 0, including `o_HSync`/`o_VSync`.
- **FSM states:** S_DRAW, S_MOVE_X, S_MOVE_Y.
  - S_DRAW→S_MOVE_X when `i_Row_Count`==`ACTIVE_ROWS` and `i_Col_Count`==0; this is the first blanking line, checked once per frame.
  - S_MOVE_X→S_MOVE_Y→S_DRAW unconditionally, 1 cycle each.
  - Position registers change only in the MOVE states, never during active video.
- **X update (S_MOVE_X):**
  - Moving right: if X+SPEED ≥ `ACTIVE_COLS`-`BALL_SIZE`, then X←`ACTIVE_COLS`-`BALL_SIZE`, direction←left, bounce flagged. Otherwise X←X+SPEED.
  - Moving left: if X ≤ SPEED, then X←0, direction←right, bounce flagged. Otherwise X←X-SPEED.
  - Compare in 11-bit arithmetic so no wrap-around is possible.
- **Y update (S_MOVE_Y):** identical rules using `ACTIVE_ROWS` and the up/down direction.
- **Bounce pulse:** `o_Bounce` pulses exactly once, on the cycle after S_MOVE_Y, when either axis bounced in this frame. A corner hit (both axes) still produces one pulse.
- **Pixel colour**, evaluated from the current inputs and registered:
  - Outside active area (`i_HSync`=0 or `i_VSync`=0): all channels 0.
  - Ball (X ≤ col < X+`BALL_SIZE` and Y ≤ row < Y+`BALL_SIZE`): 3'b111 on all channels.
  - Grid (col[2:0]==0 or row[2:0]==0): green 3'b010, others 0.
  - Otherwise: blue 3'b001, others 0.
  - Ball has priority over grid.

## Timing
- **Latency:** 1 cycle from `i_Col_Count`/`i_Row_Count`/`i_HSync`/`i_VSync` to all outputs. Sync and video stay column-aligned.
- **Position update:** completes 2 cycles after the frame trigger. `o_Bounce` follows 1 cycle later.
- **Reset mid-frame:** outputs are forced 0 immediately. After release, drawing resumes from the incoming counters with reset position. No partial move is kept.
- **Missed trigger:** if the trigger row/col is never presented (e.g. reset spans it), no move occurs that frame. The FSM never stalls.

## Structure
- Shared package `vga_pkg`: `ACTIVE_COLS`/`ACTIVE_ROWS`/`TOTAL_*` defaults, 3-bit colour constants (BLACK, WHITE, GRID_GRN, BG_BLU), FSM state encoding.
- One natural sub-module: `ball_axis_mover`. It is instantiated twice (X, Y), parameterised by limit, and holds position, direction and the bounce flag, with a move-enable input.

## Test plan
- **Reset:** hold `i_Rst_L`=0 with the counters running → all outputs 0. Release → pixel (128,128) shows 111/111/111 one cycle after presentation.
- **Pattern:** col=8,row=3 → G=010, R=B=000. col=9,row=3 → B=001. col=700 → all 000. `o_HSync` equals `i_HSync` delayed 1 cycle.
- **Motion:** after 1 frame trigger, X=130,Y=130. Pixel (129,129) is background, pixel (130,130) is white.
- **Right wall:** INIT_X=631, SPEED=2 → after the trigger X=632, direction left, `o_Bounce`=1 for exactly 1 cycle. Next frame X=630.
- **Corner:** INIT_X=1, INIT_Y=1, both directions forced negative → X=Y=0, both directions flip, a single `o_Bounce` pulse.
- **Mid-frame reset:** assert reset at row 200 → outputs 0 within the same cycle. Position returns to 128,128. Next trigger moves the ball to 130,130.
